// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM encoding and sizing helper.
package arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int cnt_w(input int b);
    return $clog2(b);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_r,
  input  logic         i_msb,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_r,
  output logic         o_q
);

  // The shifted remainder needs W+1 bits; the restored result is always < divisor, so W suffice.
  logic [W:0] w_sh;
  logic [W:0] w_diff;

  assign w_sh   = {i_r, i_msb};
  assign w_diff = w_sh - {1'b0, i_divisor};
  assign o_q    = (w_sh >= {1'b0, i_divisor});
  assign o_r    = o_q ? w_diff[W-1:0] : w_sh[W-1:0];

endmodule

// File: rtl/div_4bits.sv
// Sequential unsigned restoring divider: one quotient bit per clock, done pulse, divide-by-zero flag.
module div_4bits
  import arith_pkg::*;
#(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [bits-1:0] Dividend,
  input  logic [bits-1:0] Divisor,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] Quotient,
  output logic [bits-1:0] Remainder,
  output logic            div_by_zero
);

  localparam int CW = cnt_w(bits);

  logic [1:0]      r_state;
  logic [bits-1:0] r_dvd;
  logic [bits-1:0] r_dvs;
  logic [bits-1:0] r_quo;
  logic [bits-1:0] r_rem;
  logic [CW-1:0]   r_cnt;
  logic [bits-1:0] w_rem_nxt;
  logic            w_qbit;

  div_step #(.W(bits)) u_step (
    .i_r       (r_rem),
    .i_msb     (r_dvd[bits-1]),
    .i_divisor (r_dvs),
    .o_r       (w_rem_nxt),
    .o_q       (w_qbit)
  );

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[bits-2:0], 1'b0};
          r_quo <= {r_quo[bits-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state   <= DONE;
            Quotient  <= {r_quo[bits-2:0], w_qbit};
            Remainder <= w_rem_nxt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (Divisor == '0) begin
              // Divide-by-zero skips iteration and reports all-ones / the dividend.
              r_state     <= DONE;
              Quotient    <= '1;
              Remainder   <= Dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_state     <= CALC;
              r_dvd       <= Dividend;
              r_dvs       <= Divisor;
              r_quo       <= '0;
              r_rem       <= '0;
              r_cnt       <= CW'(bits - 1);
              div_by_zero <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_4bits.sv
// Scoreboard bench for div_4bits: directed cases, back-to-back, reset abort and a full operand sweep.
module tb_div_4bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] Dividend, Divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] Quotient, Remainder;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  div_4bits #(.bits(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .busy        (busy),
    .done        (done),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Shift/add multiplier model used to cross-check Q*D+R.
  function automatic int mul(input int x, input int y);
    int acc = 0;
    for (int i = 0; i < 4; i++)
      if (y[i]) acc += x << i;
    return acc;
  endfunction

  function automatic exp_t mk(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.z = (b == 4'd0);
    e.q = e.z ? 4'hF : 4'(int'(a) / int'(b == 0 ? 1 : b));
    e.r = e.z ? a    : 4'(int'(a) % int'(b == 0 ? 1 : b));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_and_done", {31'd0, busy & done}, 32'd0);
      if (done) begin
        exp_t e;
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("quotient", {28'd0, Quotient}, {28'd0, e.q});
          chk("remainder", {28'd0, Remainder}, {28'd0, e.r});
          chk("dbz", {31'd0, div_by_zero}, {31'd0, e.z});
          if (!e.z) begin
            chk("prod_sum", mul(Quotient, e.b) + Remainder, {28'd0, e.a});
            chk("rem_lt_div", {31'd0, Remainder < e.b}, 32'd1);
          end
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one op from IDLE, check busy length, leave the FSM back in IDLE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    int busyc = 0;
    start = 1'b1; Dividend = a; Divisor = b;
    sbq.push_back(mk(a, b));
    @(posedge clk); #1;
    start = 1'b0; Dividend = 4'($urandom); Divisor = 4'($urandom);
    while (!done && n < 40) begin
      if (busy) busyc++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_cycles", busyc, (b == 0) ? 32'd0 : 32'd4);
    @(posedge clk); #1;
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", {28'd0, Quotient}, 32'd0);
    chk("rst_r", {28'd0, Remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd13, 4'd4);
    run_op(4'd15, 4'd1);
    run_op(4'd3, 4'd7);
    run_op(4'd0, 4'd5);
    run_op(4'd15, 4'd15);
    run_op(4'd9, 4'd0);
    run_op(4'd8, 4'd2);

    // start while busy is dropped; start in the DONE cycle is accepted
    dc = done_cnt;
    start = 1'b1; Dividend = 4'd13; Divisor = 4'd4;
    sbq.push_back(mk(4'd13, 4'd4));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; Dividend = 4'd14; Divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    start = 1'b1; Dividend = 4'd14; Divisor = 4'd3;
    sbq.push_back(mk(4'd14, 4'd3));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("hold_q", {28'd0, Quotient}, 32'd3);
    chk("hold_r", {28'd0, Remainder}, 32'd1);
    wait_done();
    @(negedge clk); #1;
    chk("done_pulses", done_cnt - dc, 32'd2);
    @(posedge clk); #1;

    // reset mid-CALC aborts without a done
    start = 1'b1; Dividend = 4'd13; Divisor = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", {28'd0, Quotient}, 32'd0);
    chk("abort_r", {28'd0, Remainder}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    dc = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, dc);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    run_op(4'd7, 4'd2);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b));

    repeat (2) @(posedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
